// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the multiplexed 7-segment display controller:
//   - register indices on the CPU bus (DATA / MASK / CTRL)
//   - bit positions of the MASK and CTRL fields
//   - active-low segment codes for hex digits 0..F (bits 6:0 = g..a)
//   - BLANK_SEG, the all-off pattern including the decimal point
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  // MASK register field offsets (each field is one bit per digit)
  localparam int MASK_DP_LSB    = 0;
  localparam int MASK_BLANK_LSB = 8;
  localparam int MASK_BLINK_LSB = 16;

  // CTRL register field positions
  localparam int CTRL_BRIGHT_LSB = 0;
  localparam int CTRL_LZ_BIT     = 4;
  localparam int CTRL_BLINK_BIT  = 5;

  // Active-low segment codes, index = nibble value
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [7:0] BLANK_SEG = 8'hFF;

endpackage

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational nibble-to-segment decoder, active-low outputs.
// Ports:
//   i_nibble  in  4  hex value to display
//   i_dp      in  1  decimal point request (1 = dp lit)
//   o_seg     out 8  {dp_n, g..a}, active-low
// ---------------------------------------------------------------------------
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  assign o_seg = {~i_dp, SEG_CODE[i_nibble]};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Memory-mapped multiplexed 7-segment controller for common-anode displays.
// Scans DIGITS digits, each held for 2**SCAN_LOG2 clocks, with per-digit
// decimal point / blank / blink masks, leading-zero suppression and 16-level
// PWM brightness.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   cs, we         bus select and write enable (write when both high)
//   addr  [1:0]    register index: 0 DATA, 1 MASK, 2 CTRL, 3 reserved
//   wdata [31:0]   write data
//   rdata [31:0]   combinational readback of register at addr
//   o_seg [7:0]    segment lines, active-low, bit7 = dp
//   o_sel [DIGITS-1:0] digit selects, active-low
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int SCAN_LOG2  = 14,
  parameter int BLINK_LOG2 = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [7:0]        o_seg,
  output logic [DIGITS-1:0] o_sel
);

  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Programmable registers
  logic [4*DIGITS-1:0] r_data;
  logic [DIGITS-1:0]   r_dp_mask;
  logic [DIGITS-1:0]   r_blank_mask;
  logic [DIGITS-1:0]   r_blink_mask;
  logic [3:0]          r_bright;
  logic                r_lz_en;
  logic                r_blink_en;

  // Scan state
  logic [SCAN_LOG2-1:0] r_div_cnt;
  logic [DIG_W-1:0]     r_dig;
  logic [BLINK_LOG2:0]  r_blink_cnt;

  // Output registers
  logic [7:0]        r_seg;
  logic [DIGITS-1:0] r_sel;

  logic [3:0]        w_nib [DIGITS];
  logic [DIGITS-1:0] w_upper_zero;
  logic              w_slot_end;
  logic              w_dig_last;
  logic [3:0]        w_pwm_phase;
  logic              w_blink_off;
  logic              w_blank;
  logic [7:0]        w_seg_lit;
  logic              w_unused;

  // wdata bits with no register behind them (and the reserved index)
  assign w_unused = ^wdata;

  // ---------------- register file ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data       <= '0;
      r_dp_mask    <= '0;
      r_blank_mask <= '0;
      r_blink_mask <= '0;
      r_bright     <= 4'hF;
      r_lz_en      <= 1'b0;
      r_blink_en   <= 1'b0;
    end else if (cs && we) begin
      case (addr)
        REG_DATA: r_data <= wdata[4*DIGITS-1:0];
        REG_MASK: begin
          r_dp_mask    <= wdata[MASK_DP_LSB    +: DIGITS];
          r_blank_mask <= wdata[MASK_BLANK_LSB +: DIGITS];
          r_blink_mask <= wdata[MASK_BLINK_LSB +: DIGITS];
        end
        REG_CTRL: begin
          r_bright   <= wdata[CTRL_BRIGHT_LSB +: 4];
          r_lz_en    <= wdata[CTRL_LZ_BIT];
          r_blink_en <= wdata[CTRL_BLINK_BIT];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_DATA: rdata[4*DIGITS-1:0] = r_data;
      REG_MASK: begin
        rdata[MASK_DP_LSB    +: DIGITS] = r_dp_mask;
        rdata[MASK_BLANK_LSB +: DIGITS] = r_blank_mask;
        rdata[MASK_BLINK_LSB +: DIGITS] = r_blink_mask;
      end
      REG_CTRL: begin
        rdata[CTRL_BRIGHT_LSB +: 4] = r_bright;
        rdata[CTRL_LZ_BIT]          = r_lz_en;
        rdata[CTRL_BLINK_BIT]       = r_blink_en;
      end
      default: ;
    endcase
  end

  // ---------------- scan counters ----------------
  assign w_slot_end = &r_div_cnt;
  assign w_dig_last = (r_dig == DIG_W'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_dig       <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
      if (w_slot_end) begin
        r_dig <= w_dig_last ? '0 : r_dig + 1'b1;
        // last slot of the last digit closes a frame
        if (w_dig_last) begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- per-digit data ----------------
  // w_upper_zero[i]: every nibble from digit i up to the top digit is zero,
  // computed directly from the data slice to avoid a ripple chain.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign w_nib[gi]        = r_data[4*gi +: 4];
    assign w_upper_zero[gi] = ~|r_data[4*DIGITS-1:4*gi];
  end

  assign w_pwm_phase = r_div_cnt[SCAN_LOG2-1 -: 4];
  assign w_blink_off = r_blink_cnt[BLINK_LOG2];

  assign w_blank = r_blank_mask[r_dig]
                 | (r_blink_en & w_blink_off & r_blink_mask[r_dig])
                 | (w_pwm_phase > r_bright)
                 | (r_lz_en & (r_dig != '0) & w_upper_zero[r_dig]);

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nib[r_dig]),
    .i_dp     (r_dp_mask[r_dig]),
    .o_seg    (w_seg_lit)
  );

  // Select and segments share one register stage so they can never disagree.
  always_ff @(posedge clk) begin
    if (rst || w_blank) begin
      r_sel <= '1;
      r_seg <= BLANK_SEG;
    end else begin
      r_sel <= ~(DIGITS'(1) << r_dig);
      r_seg <= w_seg_lit;
    end
  end

  assign o_seg = r_seg;
  assign o_sel = r_sel;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Self-checking bench for seg7_scan_ctrl (DIGITS=8, SCAN_LOG2=4,
// BLINK_LOG2=1). The reference model derives the expected display from the
// number of clock edges since reset with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int D = 8;
  localparam int S = 4;
  localparam int B = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  o_seg;
  logic [D-1:0] o_sel;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan_ctrl #(.DIGITS(D), .SCAN_LOG2(S), .BLINK_LOG2(B)) dut (
    .clk   (clk),
    .rst   (rst),
    .cs    (cs),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .o_seg (o_seg),
    .o_sel (o_sel)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0]  hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] m_data;
  logic [7:0]  m_dp, m_blank, m_blink;
  logic [3:0]  m_bright;
  logic        m_lz, m_ben;
  int unsigned m_n;   // clock edges since reset release

  function automatic logic [15:0] model_out(int unsigned n);
    int unsigned slot, dig, frame, phase, nib;
    bit boff, blank, zero;
    logic [7:0] sel, seg;
    slot  = n / (1 << S);
    dig   = slot % D;
    frame = slot / D;
    boff  = ((frame / (1 << B)) % 2) == 1;
    phase = (n % (1 << S)) / (1 << (S - 4));
    blank = m_blank[dig] || (m_ben && boff && m_blink[dig]) || (phase > m_bright);
    if (m_lz && dig != 0) begin
      zero = 1'b1;
      for (int j = dig; j < D; j++) if (((m_data >> (4 * j)) & 32'hF) != 0) zero = 1'b0;
      if (zero) blank = 1'b1;
    end
    if (blank) return 16'hFFFF;
    sel      = 8'hFF;
    sel[dig] = 1'b0;
    nib      = (m_data >> (4 * dig)) & 32'hF;
    seg      = {~m_dp[dig], hex_tbl[nib]};
    return {sel, seg};
  endfunction

  function automatic logic [31:0] model_rd(logic [1:0] a);
    case (a)
      2'd0:    return m_data;
      2'd1:    return {8'h00, m_blink, m_blank, m_dp};
      2'd2:    return {26'h0, m_ben, m_lz, m_bright};
      default: return 32'h0;
    endcase
  endfunction

  // Advance one clock: returns the output expected just after this edge,
  // then applies this edge's reset/write to the model.
  task automatic tick(output logic [15:0] e);
    if (rst) e = 16'hFFFF;
    else     e = model_out(m_n);
    @(posedge clk);
    if (rst) begin
      m_data = 0; m_dp = 0; m_blank = 0; m_blink = 0;
      m_bright = 4'hF; m_lz = 0; m_ben = 0; m_n = 0;
    end else begin
      if (cs && we) begin
        case (addr)
          2'd0: m_data = wdata;
          2'd1: begin m_dp = wdata[7:0]; m_blank = wdata[15:8]; m_blink = wdata[23:16]; end
          2'd2: begin m_bright = wdata[3:0]; m_lz = wdata[4]; m_ben = wdata[5]; end
          default: ;
        endcase
      end
      m_n++;
    end
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [15:0] e;
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick(e);
    cs = 1'b0; we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [15:0] e;
    rst = 1'b1;
    tick(e);
    tick(e);
    n_tests++;
    if (o_sel !== 8'hFF || o_seg !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_out got sel=%h seg=%h exp sel=FF seg=FF", o_sel, o_seg);
    end
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      n_tests++;
      if (rdata !== model_rd(2'(a))) begin
        n_fail++;
        $display("FAIL reset_rd addr=%0d got=%h exp=%h", a, rdata, model_rd(2'(a)));
      end
    end
    rst = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_scan;
    logic [15:0] e;
    wr(2'd0, 32'h89AB_CDEF);
    wr(2'd2, 32'h0000_000F);
    for (int i = 0; i < 256; i++) begin
      tick(e);
      n_tests++;
      if ({o_sel, o_seg} !== e) begin
        n_fail++;
        $display("FAIL scan cyc=%0d got=%h exp=%h", m_n, {o_sel, o_seg}, e);
      end
      if (o_sel == 8'hFE && o_seg !== 8'h8E) begin
        n_fail++;
        $display("FAIL scan_dig0 got seg=%h exp=8E", o_seg);
      end
    end
    $display("[TB] test_scan done");
  endtask

  task automatic test_dp;
    logic [15:0] e;
    wr(2'd1, 32'h0000_0005);
    for (int i = 0; i < 128; i++) begin
      tick(e);
      n_tests++;
      if ({o_sel, o_seg} !== e) begin
        n_fail++;
        $display("FAIL dp cyc=%0d got=%h exp=%h", m_n, {o_sel, o_seg}, e);
      end
      if ((o_sel == 8'hFE && o_seg !== 8'h0E) || (o_sel == 8'hFB && o_seg !== 8'h21)) begin
        n_fail++;
        $display("FAIL dp_direct sel=%h got seg=%h", o_sel, o_seg);
      end
    end
    $display("[TB] test_dp done");
  endtask

  task automatic test_lz;
    logic [15:0] e;
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h0000_0120);
    wr(2'd2, 32'h0000_001F);
    for (int i = 0; i < 128; i++) begin
      tick(e);
      n_tests++;
      if ({o_sel, o_seg} !== e) begin
        n_fail++;
        $display("FAIL lz cyc=%0d got=%h exp=%h", m_n, {o_sel, o_seg}, e);
      end
      if (o_sel[7:3] !== 5'h1F) begin
        n_fail++;
        $display("FAIL lz_upper got sel=%h exp upper digits off", o_sel);
      end
    end
    wr(2'd0, 32'h0);
    for (int i = 0; i < 128; i++) begin
      tick(e);
      n_tests++;
      if ({o_sel, o_seg} !== e || (o_sel != 8'hFF && {o_sel, o_seg} !== 16'hFEC0)) begin
        n_fail++;
        $display("FAIL lz_zero cyc=%0d got=%h exp=%h", m_n, {o_sel, o_seg}, e);
      end
    end
    $display("[TB] test_lz done");
  endtask

  task automatic test_pwm;
    logic [15:0] e;
    int lit [D];
    wr(2'd0, $urandom);
    wr(2'd2, 32'h0000_0003);
    for (int d = 0; d < D; d++) lit[d] = 0;
    for (int i = 0; i < 128; i++) begin
      tick(e);
      n_tests++;
      if ({o_sel, o_seg} !== e) begin
        n_fail++;
        $display("FAIL pwm cyc=%0d got=%h exp=%h", m_n, {o_sel, o_seg}, e);
      end
      for (int d = 0; d < D; d++) if (o_sel[d] === 1'b0) lit[d]++;
    end
    for (int d = 0; d < D; d++) begin
      n_tests++;
      if (lit[d] != 4) begin
        n_fail++;
        $display("FAIL pwm_duty digit=%0d got lit=%0d exp=4", d, lit[d]);
      end
    end
    $display("[TB] test_pwm done");
  endtask

  task automatic test_blink;
    logic [15:0] e;
    wr(2'd1, 32'h0001_0000);
    wr(2'd2, 32'h0000_002F);
    for (int i = 0; i < 6 * 128; i++) begin
      tick(e);
      n_tests++;
      if ({o_sel, o_seg} !== e) begin
        n_fail++;
        $display("FAIL blink cyc=%0d got=%h exp=%h", m_n, {o_sel, o_seg}, e);
      end
    end
    $display("[TB] test_blink done");
  endtask

  task automatic test_random;
    logic [15:0] e;
    int len;
    for (int it = 0; it < 16; it++) begin
      wr(2'd0, $urandom);
      wr(2'd1, $urandom & 32'h00FF_F0FF);  // keep blank mask sparse
      wr(2'd2, $urandom_range(0, 63));
      for (int a = 0; a < 4; a++) begin
        addr = 2'(a); #1;
        n_tests++;
        if (rdata !== model_rd(2'(a))) begin
          n_fail++;
          $display("FAIL rand_rd addr=%0d got=%h exp=%h", a, rdata, model_rd(2'(a)));
        end
      end
      len = $urandom_range(100, 300);
      for (int i = 0; i < len; i++) begin
        tick(e);
        n_tests++;
        if ({o_sel, o_seg} !== e) begin
          n_fail++;
          $display("FAIL rand it=%0d cyc=%0d got=%h exp=%h", it, m_n, {o_sel, o_seg}, e);
        end
      end
      $display("[TB] test_random iteration %0d done", it);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] e;
    for (int i = 0; i < 300; i++) begin
      cs = 1'b1; we = 1'b1;
      addr  = 2'($urandom_range(0, 3));
      wdata = (addr == 2'd1) ? ($urandom & 32'h00FF_F0FF) : $urandom;
      tick(e);
      n_tests++;
      if ({o_sel, o_seg} !== e) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", m_n, {o_sel, o_seg}, e);
      end
    end
    cs = 1'b0; we = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      n_tests++;
      if (rdata !== model_rd(2'(a))) begin
        n_fail++;
        $display("FAIL b2b_rd addr=%0d got=%h exp=%h", a, rdata, model_rd(2'(a)));
      end
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_reset_mid;
    logic [15:0] e;
    logic [31:0] rst_val [4];
    bit found;
    rst_val[0] = 32'h0; rst_val[1] = 32'h0; rst_val[2] = 32'h0000_000F; rst_val[3] = 32'h0;
    wr(2'd0, 32'h1234_5678);
    wr(2'd2, 32'h0000_000F);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (((m_n >> S) % D) == 5 && (m_n % (1 << S)) == 7) found = 1'b1;
      else tick(e);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL rst_mid_seek got no dig5 slot exp found");
    end
    rst = 1'b1;
    tick(e);
    n_tests++;
    if (o_sel !== 8'hFF || o_seg !== 8'hFF) begin
      n_fail++;
      $display("FAIL rst_mid_out got sel=%h seg=%h exp FF FF", o_sel, o_seg);
    end
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      n_tests++;
      if (rdata !== rst_val[a]) begin
        n_fail++;
        $display("FAIL rst_mid_rd addr=%0d got=%h exp=%h", a, rdata, rst_val[a]);
      end
    end
    tick(e);
    n_tests++;
    if ({o_sel, o_seg} !== 16'hFEC0) begin
      n_fail++;
      $display("FAIL rst_mid_restart got=%h exp=FEC0", {o_sel, o_seg});
    end
    for (int i = 0; i < 64; i++) begin
      tick(e);
      n_tests++;
      if ({o_sel, o_seg} !== e) begin
        n_fail++;
        $display("FAIL rst_mid_scan cyc=%0d got=%h exp=%h", m_n, {o_sel, o_seg}, e);
      end
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    m_data = 0; m_dp = 0; m_blank = 0; m_blink = 0;
    m_bright = 4'hF; m_lz = 0; m_ben = 0; m_n = 0;
    test_reset;
    test_scan;
    test_dp;
    test_lz;
    test_pwm;
    test_blink;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
